// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
// The state encoding here is also what the FSM reports on its debug port.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int PRESCALE_X8  = 8;
  localparam int PRESCALE_X16 = 16;
  localparam int PRESCALE_X32 = 32;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and data-bit counter for the UART receiver.
// Holds the latched prescale (stored as its last edge index) and flags the last edge of each bit.
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cnt_en,
  input  logic                      bit_en,
  input  logic                      clr,
  input  logic                      load,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      last_edge,
  output logic                      last_bit
);

  logic [PRESCALE_WIDTH-1:0] edge_last;

  assign last_edge = cnt_en && (edge_cnt == edge_last);
  assign last_bit  = (bit_cnt == 4'(DATA_WIDTH - 1));

  // Storing P-1 keeps the per-cycle compare a plain equality.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_last <= '0;
    end else if (load) begin
      edge_last <= prescale - PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
    end else if (cnt_en) begin
      edge_cnt <= last_edge ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (bit_en && last_edge) begin
      bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: walks start/data/parity/stop, issues one-cycle check and
// shift strobes on the last oversampling edge of each bit, and flags clean frames.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      sampled_bit,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic                      dat_samp_en,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      deser_en,
  output logic                      data_valid,
  output logic [2:0]                fsm_state
);

  rx_state_e state;
  logic      err_flag;
  logic      last_edge;
  logic      last_bit;

  // sampled_bit goes straight to the deserializer in the parent; only its timing matters here.
  logic unused_sampled_bit;
  assign unused_sampled_bit = sampled_bit;

  edge_bit_counter #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_counter (
    .clk       (CLK),
    .rst_n     (RST),
    .cnt_en    (state != IDLE),
    .bit_en    (state == DATA),
    .clr       (state == IDLE),
    .load      ((state == IDLE) && (RX_IN == START_BIT)),
    .prescale  (Prescale),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .last_edge (last_edge),
    .last_bit  (last_bit)
  );

  assign fsm_state   = state;
  assign dat_samp_en = (state != IDLE);
  assign strt_chk_en = (state == START)  && last_edge;
  assign deser_en    = (state == DATA)   && last_edge;
  assign par_chk_en  = (state == PARITY) && last_edge;
  assign stp_chk_en  = (state == STOP)   && last_edge;

  // Handshake: data_valid is a one-cycle pulse with no ready; the consumer must take it that cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      err_flag   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_IN == START_BIT) state <= START;
        end
        START: begin
          if (last_edge) state <= strt_glitch ? IDLE : DATA;
        end
        DATA: begin
          if (last_edge && last_bit) state <= PAR_EN ? PARITY : STOP;
        end
        PARITY: begin
          // A parity failure does not abort the frame, so stop-bit timing stays intact.
          if (last_edge) begin
            err_flag <= par_err;
            state    <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            data_valid <= !stp_err && !err_flag;
            err_flag   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized scoreboard bench for uart_rx_fsm: the driver plays the serial line and the
// per-bit checkers, pushing the expected strobe/valid events; a monitor pops and compares.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int W  = 45;  // {kind[3], cycle[24], data[8], edge[6], bit[4]}

  localparam logic [2:0] K_STRT  = 3'd1;
  localparam logic [2:0] K_DESER = 3'd2;
  localparam logic [2:0] K_PAR   = 3'd3;
  localparam logic [2:0] K_STP   = 3'd4;
  localparam logic [2:0] K_VALID = 3'd5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic [PW-1:0] Prescale = PW'(8);
  logic          sampled_bit = 1'b1;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          strt_chk_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          deser_en;
  logic          data_valid;
  logic [2:0]    fsm_state;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  sr = 8'h00;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .sampled_bit (sampled_bit),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion by 3 ms, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input logic [2:0] kind, input int c, input logic [7:0] data,
                                      input int e, input int b);
    return {kind, 24'(c), data, 6'(e), 4'(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_dat_samp_en"}, 32'(dat_samp_en), 0);
    check({tag, "_edge_cnt"},    32'(edge_cnt), 0);
    check({tag, "_bit_cnt"},     32'(bit_cnt), 0);
    check({tag, "_strt_chk_en"}, 32'(strt_chk_en), 0);
    check({tag, "_par_chk_en"},  32'(par_chk_en), 0);
    check({tag, "_stp_chk_en"},  32'(stp_chk_en), 0);
    check({tag, "_deser_en"},    32'(deser_en), 0);
    check({tag, "_data_valid"},  32'(data_valid), 0);
    check({tag, "_state_idle"},  32'(fsm_state), 0);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic scramble_prescale();
    Prescale = PW'(8 << $urandom_range(0, 2));
  endtask

  // ---------------- driver ----------------
  // Starts in an IDLE cycle (1 time unit after a clock edge). abort_bit >= 0 resets
  // the DUT two cycles into that data bit.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit par_bad,
                            input bit stp_bad, input bit brk, input int abort_bit);
    int   k;
    int   nslots;
    logic bitval;
    k = cyc;
    nslots = DW + 2 + int'(pe);
    // Reference timeline: bit slot j covers cycles k+1+j*p .. k+(j+1)*p.
    exp_q.push_back(ev(K_STRT, k + p, 8'h00, p - 1, 0));
    for (int i = 0; i < DW; i++)
      if (abort_bit < 0 || i < abort_bit)
        exp_q.push_back(ev(K_DESER, k + (i + 2) * p, 8'h00, p - 1, i));
    if (abort_bit < 0) begin
      if (pe) exp_q.push_back(ev(K_PAR, k + (DW + 2) * p, 8'h00, p - 1, 0));
      exp_q.push_back(ev(K_STP, k + nslots * p, 8'h00, p - 1, 0));
      if (!(pe && par_bad) && !stp_bad)
        exp_q.push_back(ev(K_VALID, k + nslots * p + 1, d, 0, 0));
    end

    Prescale = PW'(p); PAR_EN = pe; RX_IN = 1'b0; sampled_bit = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    @(posedge CLK); #1;
    scramble_prescale();
    for (int s = 0; s < nslots; s++) begin
      if (s == 0)                    bitval = 1'b0;
      else if (s <= DW)              bitval = d[s-1];
      else if (pe && s == DW + 1)    bitval = ^d;
      else                           bitval = !brk;
      RX_IN = bitval; sampled_bit = bitval;
      par_err = pe && (s == DW + 1) && par_bad;
      stp_err = (s == nslots - 1) && stp_bad;
      for (int c = 0; c < p; c++) begin
        if (abort_bit >= 0 && s == abort_bit + 1 && c == 2) begin
          #2 RST = 1'b0;
          #1 reset_checks("abort");
          RX_IN = 1'b1; sampled_bit = 1'b1; par_err = 1'b0; stp_err = 1'b0;
          repeat (2) @(posedge CLK);
          #2 RST = 1'b1;
          @(posedge CLK); #1;
          return;
        end
        @(posedge CLK); #1;
      end
    end
    RX_IN = !brk; sampled_bit = !brk; par_err = 1'b0; stp_err = 1'b0;
  endtask

  task automatic send_glitch(input int p);
    int k;
    k = cyc;
    exp_q.push_back(ev(K_STRT, k + p, 8'h00, p - 1, 0));
    Prescale = PW'(p); RX_IN = 1'b0; sampled_bit = 1'b0; strt_glitch = 1'b1;
    @(posedge CLK); #1;
    scramble_prescale();
    for (int c = 0; c < p; c++) begin
      if (c == 2) begin RX_IN = 1'b1; sampled_bit = 1'b1; end
      @(posedge CLK); #1;
    end
    strt_glitch = 1'b0; RX_IN = 1'b1;
    check("glitch_back_idle", 32'(fsm_state), 0);
    check("glitch_bit_cnt", 32'(bit_cnt), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic observe(input logic [2:0] kind, input logic [7:0] data);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {kind, 24'(cyc), data, edge_cnt, bit_cnt};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%02h, expected no event",
               kind, cyc, data);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL event: got kind=%0d cyc=%0d data=%02h edge=%0d bit=%0d, expected kind=%0d cyc=%0d data=%02h edge=%0d bit=%0d",
                 act[44:42], act[41:18], act[17:10], act[9:4], act[3:0],
                 exp[44:42], exp[41:18], exp[17:10], exp[9:4], exp[3:0]);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (deser_en) sr = {sampled_bit, sr[7:1]};
      if (strt_chk_en) observe(K_STRT, 8'h00);
      if (deser_en)    observe(K_DESER, 8'h00);
      if (par_chk_en)  observe(K_PAR, 8'h00);
      if (stp_chk_en)  observe(K_STP, 8'h00);
      if (data_valid)  observe(K_VALID, sr);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          p;
    bit          pe;
    bit          pb;
    bit          sb;
    logic [7:0]  d;
    int          gap;

    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset_checks("reset");
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(3);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idle(1);
    d = 8'($urandom_range(0, 255));
    send_frame(d, 16, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    send_glitch(8);
    idle(2);
    // stop error followed by a back-to-back frame
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
    // break: line held low through the stop bit, then the held-low restart is rejected
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    send_glitch(8);
    idle(2);
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    idle(4);
    check("post_abort_idle", 32'(fsm_state), 0);
    send_frame(8'h81, 32, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(1);

    for (int i = 0; i < 12; i++) begin
      p   = 8 << $urandom_range(0, 2);
      pe  = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      pb  = ($urandom_range(0, 3) == 0);
      sb  = ($urandom_range(0, 3) == 0);
      send_frame(d, p, pe, pb, sb, 1'b0, -1);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
    end

    idle(5);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
